// File: rtl/ibex_pkg.sv
// Shared Ibex definitions used by the fetch path.
package ibex_pkg;

  localparam int unsigned FetchFifoDepth = 3;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } fetch_entry_t;

endpackage

// File: rtl/ibex_fetch_align_fifo.sv
// Fetch buffer: stores fetched words and presents one realigned (possibly
// compressed or word-straddling) instruction per handshake, with its PC.
module ibex_fetch_align_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth    = FetchFifoDepth,
  parameter bit          ResetAll = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [31:0] clear_addr_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o,
  output logic        out_err_plus2_o,
  output logic        busy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [31:0]     rdata_q [Depth];
  logic            err_q   [Depth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_p1;
  logic [CntW-1:0] count_q;
  logic [31:0]     addr_q;

  fetch_entry_t w0;
  logic [15:0]  w1_lo;
  logic         w1_err;
  logic         has1, has2, unaligned, lo_comp, hi_comp;
  logic         push, pop, accept, pop_on_accept;
  logic [31:0]  addr_incr;
  logic         unused_clear_addr_lsb;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic is_compressed(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  assign unused_clear_addr_lsb = clear_addr_i[0];

  assign rd_ptr_p1 = ptr_inc(rd_ptr_q);
  assign w0        = '{rdata: rdata_q[rd_ptr_q], err: err_q[rd_ptr_q]};
  assign w1_lo     = rdata_q[rd_ptr_p1][15:0];
  assign w1_err    = err_q[rd_ptr_p1];

  assign has1      = count_q != '0;
  assign has2      = count_q >= CntW'(2);
  assign unaligned = addr_q[1];
  assign lo_comp   = is_compressed(w0.rdata[15:0]);
  assign hi_comp   = is_compressed(w0.rdata[31:16]);

  always_comb begin
    out_valid_o     = has1;
    out_rdata_o     = w0.rdata;
    addr_incr       = 32'd4;
    pop_on_accept   = 1'b1;
    out_err_plus2_o = 1'b0;
    if (!unaligned) begin
      if (lo_comp) begin
        addr_incr     = 32'd2;
        pop_on_accept = 1'b0;
      end
    end else if (hi_comp) begin
      out_rdata_o = {16'h0000, w0.rdata[31:16]};
      addr_incr   = 32'd2;
    end else begin
      out_valid_o     = has2 | (has1 & w0.err);
      out_err_plus2_o = has2 & !w0.err & w1_err;
      // An errored first half may be presented before w1 arrives; leaving
      // w1 out of the data keeps it stable if w1 is pushed while stalled.
      out_rdata_o = w0.err ? {16'h0000, w0.rdata[31:16]}
                           : {w1_lo, w0.rdata[31:16]};
    end
  end

  assign out_err_o  = (has1 & w0.err) | (unaligned & !hi_comp & has2 & w1_err);
  assign out_addr_o = addr_q;
  assign in_ready_o = count_q < DepthCnt;
  assign busy_o     = has1;

  assign push   = in_valid_i & in_ready_o & !clear_i;
  assign accept = out_valid_o & out_ready_i & !clear_i;
  assign pop    = accept & pop_on_accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= {clear_addr_i[31:1], 1'b0};
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= rd_ptr_p1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
      if (accept) addr_q <= addr_q + addr_incr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) err_q[i] <= 1'b0;
    end else if (push) begin
      err_q[wr_ptr_q] <= in_err_i;
    end
  end

  if (ResetAll) begin : g_rdata_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < Depth; i++) rdata_q[i] <= '0;
      end else if (push) begin
        rdata_q[wr_ptr_q] <= in_rdata_i;
      end
    end
  end else begin : g_rdata_norst
    always_ff @(posedge clk_i) begin
      if (push) rdata_q[wr_ptr_q] <= in_rdata_i;
    end
  end

  push_while_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (in_valid_i && !clear_i) |-> in_ready_o);

endmodule

// File: doc/ibex_fetch_align_fifo.md
Name: ibex_fetch_align_fifo

Overview:
- Parametrised fetch buffer placed between the instruction-memory response path and the IF-ID pipeline register.
- Stores fetched 32-bit words in a Depth-entry FIFO and presents one realigned instruction per handshake.
- Handles 16-bit-aligned PCs: compressed instructions at any halfword, and 32-bit instructions straddling two words.
- Tracks the PC of the presented instruction. Error flags are tagged per word, so a bus error is attributed to the exact fetch that caused it.

Parameters:
- Depth, 3, number of 32-bit word entries; legal range 2..8.
- ResetAll, 1'b0, when 1 the word storage is also reset to zero; otherwise only control state is reset.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  flush FIFO and restart at clear_addr_i
- clear_addr_i  in  32  new PC; bit 0 ignored
- in_valid_i  in  1  fetched word valid
- in_rdata_i  in  32  fetched word, word-aligned
- in_err_i  in  1  bus/PMP error on this word
- in_ready_o  out  1  space available: count < Depth
- out_valid_o  out  1  complete instruction available
- out_ready_i  in  1  consumer accepts instruction
- out_rdata_o  out  32  realigned instruction; upper 16 bits don't-care when compressed
- out_addr_o  out  32  PC of the presented instruction
- out_err_o  out  1  instruction has a fetch error
- out_err_plus2_o  out  1  error lies only in the second half (word addr+4)
- busy_o  out  1  count != 0

Behaviour:
- Reset (rst_ni asynchronous, active-low; clock clk_i): count=0, out_addr_o=0, all entry valid/err bits=0. Outputs then read out_valid_o=0, in_ready_o=1, busy_o=0, out_err_o=0, out_err_plus2_o=0.
- Storage: circular buffer with rd_ptr, wr_ptr and count (width $clog2(Depth+1)). Pointers wrap modulo Depth; Depth need not be a power of 2.
- Push: occurs when in_valid_i & in_ready_o & !clear_i. A pushed word is visible to the output the next cycle; there is no bypass.
- Push while !in_ready_o: the word is dropped and state is unchanged. This is a protocol violation and an assertion must fire.
- Let w0 be the entry at rd_ptr and w1 the entry at rd_ptr+1. A halfword is compressed when its bits [1:0] != 2'b11.
- Case out_addr_o[1]=0:
  - out_valid_o = count>=1; out_rdata_o = w0.
  - If w0[15:0] is compressed: addr += 2, no pop. Otherwise: addr += 4, pop 1.
- Case out_addr_o[1]=1, with h = w0[31:16]:
  - If h is compressed: out_valid_o = count>=1; out_rdata_o = {16'h0, h}; addr += 2, pop 1.
  - Otherwise: out_valid_o = count>=2, or count>=1 with w0 err; out_rdata_o = {w1[15:0], h}; addr += 4, pop 1. The upper half of w1 remains, so addr[1] stays 1.
- Every accepted instruction pops at most 1 word. Push and pop in the same cycle leave count unchanged.
- Errors:
  - out_err_o = w0.err, OR (unaligned uncompressed AND w1.err AND count>=2).
  - out_err_plus2_o = unaligned uncompressed & !w0.err & w1.err.
  - An errored w0 forces out_valid_o=1 even when w1 is absent.
- Address arithmetic is modulo 2^32: 0xFFFF_FFFE + 2 = 0x0000_0000.
- Clear:
  - Next cycle: count=0, pointers=0, out_addr_o = {clear_addr_i[31:1], 1'b0}.
  - A push in the same cycle is discarded and a pop in the same cycle is ignored.
  - clear_i has priority over all other events.
- Handshake:
  - out_rdata_o, out_addr_o and out_err_o hold stable while out_valid_o & !out_ready_i.
  - out_valid_o has no combinational dependency on out_ready_i.
  - in_ready_o has no combinational dependency on out_ready_i.

Decomposition:
- ibex_pkg gains the FetchFifoDepth default and a fetch_entry_t struct {logic [31:0] rdata; logic err;}.
- Single module, no sub-module. The compressed-halfword test is a local function.

Test Plan:
- Aligned 32-bit stream: clear to 0x80, push 0x00000013, 0x00100093 -> out 0x00000013 @0x80, then 0x00100093 @0x84; count returns to 0.
- Compressed pair: clear to 0x100, push 0x45014401 -> out 0x4401 @0x100 with no pop, then 0x4501 @0x102 with pop; out_valid_o then drops.
- Straddle: clear to 0x202, push 0x0013AAAA then 0xBBBB0000 -> out_valid_o=0 after the first push. After the second push: out 0x00000013 @0x202, addr becomes 0x206, count=1.
- Error in second word: clear to 0x302, push 0x0013xxxx (err=0), then a word with err=1 -> out_err_o=1, out_err_plus2_o=1.
- Full/clear race: Depth=3, fill 3 words -> in_ready_o=0. Assert clear_i(0x400) together with in_valid_i -> next cycle count=0, addr=0x400, the pushed word is absent.
- Reset mid-stream: rst_ni low with count=2 -> asynchronously out_valid_o=0, busy_o=0, in_ready_o=1.
